// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory for the 5-stage core.
// Word RAM (addr[31]=0) plus an MMIO page (addr[31]=1) with GPIO, timer and UART TX.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   dmem_we           word write strobe from the MEM stage
//   dmem_addr         byte address; [1:0] ignored
//   dmem_wdata        store data
//   data_readM        combinational read data
//   gpio_out          GPIO output register
//   timer_irq         registered mtime >= mtimecmp
//   uart_tx           serial TX line, idle high
// Build option: define DMEM_MMIO_UART_EN to include the UART transmitter.
module dmem_mmio #(
    parameter int DMEM_DEPTH = 1024,
    parameter int CLK_DIV    = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] data_readM,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        uart_tx
);

    localparam int AW = $clog2(DMEM_DEPTH);

    localparam logic [7:0] OFF_GPIO  = 8'h00;
    localparam logic [7:0] OFF_MTIME = 8'h04;
    localparam logic [7:0] OFF_MCMP  = 8'h08;
    localparam logic [7:0] OFF_UDATA = 8'h0C;
    localparam logic [7:0] OFF_USTAT = 8'h10;

    logic [31:0]   mem [DMEM_DEPTH];
    logic [AW-1:0] idx;
    logic          mmio;
    logic [7:0]    off;
    logic          mmio_we;
    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic [31:0]   mmio_rdata;
    logic          busy;
    logic          unused_addr;

    assign mmio    = dmem_addr[31];
    assign off     = dmem_addr[7:0];
    assign idx     = dmem_addr[AW+1:2];
    assign mmio_we = dmem_we && mmio;

    // Only part of the address is decoded; the rest aliases.
    assign unused_addr = ^dmem_addr;

    // Async read gives old data when a write hits the same word.
    always_ff @(posedge clk) begin
        if (dmem_we && !mmio) begin
            mem[idx] <= dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out  <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
            // A software load wins over the free-running increment.
            if (mmio_we && off == OFF_MTIME) begin
                mtime <= dmem_wdata;
            end else begin
                mtime <= mtime + 32'd1;
            end
            if (mmio_we && off == OFF_MCMP) begin
                mtimecmp <= dmem_wdata;
            end
            if (mmio_we && off == OFF_GPIO) begin
                gpio_out <= dmem_wdata;
            end
        end
    end

    always_comb begin
        mmio_rdata = '0;
        unique case (1'b1)
            (off == OFF_GPIO):  mmio_rdata = gpio_out;
            (off == OFF_MTIME): mmio_rdata = mtime;
            (off == OFF_MCMP):  mmio_rdata = mtimecmp;
            (off == OFF_USTAT): mmio_rdata = {31'd0, busy};
            default:            mmio_rdata = '0;
        endcase
    end

    assign data_readM = mmio ? mmio_rdata : mem[idx];

`ifdef DMEM_MMIO_UART_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    uart_state_t state;
    uart_state_t state_nx;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          tx_bit;
    logic          uart_wr;
    logic          baud_done;

    assign uart_wr   = mmio_we && off == OFF_UDATA;
    assign baud_done = (baud == BAUD_LAST);
    assign busy      = (state != S_IDLE);
    assign uart_tx   = tx_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

    // Both counters restart on every state entry so each
    // state/bit lasts exactly CLK_DIV cycles.
    always_comb begin
        state_nx = state;
        baud_nx  = baud + 1'b1;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        tx_bit   = 1'b1;
        unique case (state)
            S_IDLE: begin
                baud_nx = '0;
                bit_nx  = '0;
                if (uart_wr) begin
                    shreg_nx = dmem_wdata[7:0];
                    state_nx = S_START;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                if (baud_done) begin
                    state_nx = S_DATA;
                    baud_nx  = '0;
                    bit_nx   = '0;
                end
            end
            S_DATA: begin
                tx_bit = shreg[bit_idx];
                if (baud_done) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                tx_bit = 1'b1;
                if (baud_done) begin
                    state_nx = S_IDLE;
                    baud_nx  = '0;
                    bit_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`else

    assign busy    = 1'b0;
    assign uart_tx = 1'b1;

`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio.
// Covers RAM aliasing, read-during-write, timer, MMIO map and UART frame.
module tb_dmem_mmio;

    localparam int DEPTH = 1024;
    localparam int DIV   = 4;

    logic        clk;
    logic        rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] data_readM;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        uart_tx;

    int n_chk;
    int n_pass;

    dmem_mmio #(
        .DMEM_DEPTH(DEPTH),
        .CLK_DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .data_readM(data_readM),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_we    = 1'b1;
        dmem_addr  = a;
        dmem_wdata = d;
        @(posedge clk);
        #1;
        dmem_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        dmem_addr = a;
        #1;
        d = data_readM;
    endtask

    logic [31:0] v;
    logic [7:0]  fb;
    logic        exp_tx;

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b1;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h8000_0004;
        dmem_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rd(32'h8000_0004, v);
        check("rst_mtime", v, 32'h0);
        rd(32'h8000_0008, v);
        check("rst_mtimecmp", v, 32'hFFFF_FFFF);
        rd(32'h8000_0010, v);
        check("rst_stat", v, 32'h0);
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_irq", {31'd0, timer_irq}, 32'h0);
        check("rst_tx", {31'd0, uart_tx}, 32'h1);
        @(posedge clk);
        #1;

        // Timer compare
        wr(32'h8000_0008, 32'd20);
        wr(32'h8000_0004, 32'd0);
        rd(32'h8000_0008, v);
        check("mtimecmp_rd", v, 32'd20);
        for (int i = 0; i < 26; i++) begin
            dmem_addr = 32'h8000_0004;
            #1;
            check("mtime", data_readM, i);
            check("irq", {31'd0, timer_irq},
                  (i >= 21) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end

        // RAM write and aliasing
        wr(32'h0000_0100, 32'hDEAD_BEEF);
        rd(32'h0000_0100, v);
        check("ram_rd", v, 32'hDEAD_BEEF);
        rd(32'h0000_0100 + 4 * DEPTH, v);
        check("ram_alias", v, 32'hDEAD_BEEF);
        rd(32'h7000_0102, v);
        check("ram_hi_bits", v, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // MMIO write must not touch RAM
        wr(32'h8000_0100, 32'h1234_5678);
        check("gpio_via_page", gpio_out, 32'h1234_5678);
        rd(32'h0000_0100, v);
        check("ram_no_mmio", v, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Read during write returns old data
        wr(32'h0000_0200, 32'h1111_1111);
        dmem_we    = 1'b1;
        dmem_addr  = 32'h0000_0200;
        dmem_wdata = 32'h0000_0022;
        #1;
        check("rdw_old", data_readM, 32'h1111_1111);
        @(posedge clk);
        #1;
        dmem_we = 1'b0;
        #1;
        check("rdw_new", data_readM, 32'h0000_0022);

        // Unmapped offsets and GPIO
        rd(32'h8000_0020, v);
        check("unmapped_rd", v, 32'h0);
        wr(32'h8000_0020, 32'hFFFF_FFFF);
        rd(32'h8000_0020, v);
        check("unmapped_wr", v, 32'h0);
        check("gpio_keep", gpio_out, 32'h1234_5678);
        wr(32'h8000_0000, 32'h0000_00A5);
        check("gpio_a5", gpio_out, 32'h0000_00A5);
        rd(32'h8000_0000, v);
        check("gpio_rd", v, 32'h0000_00A5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("gpio_rst", gpio_out, 32'h0);
        rd(32'h0000_0100, v);
        check("ram_survives_rst", v, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

`ifdef DMEM_MMIO_UART_EN
        // Full frame of 0x55, with a dropped write mid-frame and one
        // on the cycle that leaves STOP.
        fb = 8'h55;
        wr(32'h8000_000C, 32'h0000_0055);
        for (int c = 0; c < 44; c++) begin
            if (c < 4) begin
                exp_tx = 1'b0;
            end else if (c < 36) begin
                exp_tx = fb[(c - 4) / 4];
            end else begin
                exp_tx = 1'b1;
            end
            if (c == 6 || c == 39) begin
                dmem_we    = 1'b1;
                dmem_addr  = 32'h8000_000C;
                dmem_wdata = (c == 6) ? 32'hAA : 32'h0F;
            end else begin
                dmem_we   = 1'b0;
                dmem_addr = 32'h8000_0010;
            end
            #1;
            check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
            if (dmem_we) begin
                check("udata_rd", data_readM, 32'h0);
            end else begin
                check("busy", data_readM,
                      (c < 40) ? 32'd1 : 32'd0);
            end
            @(posedge clk);
            #1;
            dmem_we = 1'b0;
        end

        // Reset in the middle of bit 3
        wr(32'h8000_000C, 32'h0000_0055);
        repeat (17) @(posedge clk);
        #1;
        check("tx_bit3", {31'd0, uart_tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("tx_after_rst", {31'd0, uart_tx}, 32'h1);
        rd(32'h8000_0010, v);
        check("stat_after_rst", v, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("tx_stays_idle", {31'd0, uart_tx}, 32'h1);
`else
        // Without the UART the registers are inert
        wr(32'h8000_000C, 32'h0000_0055);
        check("tx_tied", {31'd0, uart_tx}, 32'h1);
        rd(32'h8000_0010, v);
        check("stat_zero", v, 32'h0);
        rd(32'h8000_000C, v);
        check("udata_zero", v, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("tx_tied_later", {31'd0, uart_tx}, 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
